branch_feedback_queue: RTL
==========================

BRANCH_FEEDBACK_QUEUE -- requirements
Module: branch_feedback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight branch entries; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH, PC/target width.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_push_valid  input  1  decode-stage branch prediction issued.
REQ-006 i_push_pc  input  ADDR_W  branch PC.
REQ-007 i_push_target  input  ADDR_W  decoded branch target.
REQ-008 i_push_prediction  input  mips_core_pkg::BranchOutcome  predictor output for this branch.
REQ-009 o_push_ready  output  1  queue can accept a push this cycle.
REQ-010 i_res_valid  input  1  execute stage resolves the oldest branch.
REQ-011 i_res_outcome  input  mips_core_pkg::BranchOutcome  actual direction.
REQ-012 i_flush  input  1  external pipeline flush.
REQ-013 o_fb_valid  output  1  feedback pulse to the predictor (i_fb_valid).
REQ-014 o_fb_pc  output  ADDR_W  feedback PC (i_fb_pc).
REQ-015 o_fb_prediction  output  BranchOutcome  stored prediction (i_fb_prediction).
REQ-016 o_fb_outcome  output  BranchOutcome  resolved outcome (i_fb_outcome).
REQ-017 o_mispredict  output  1  pulse, resolved outcome != stored prediction.
REQ-018 o_recover_pc  output  ADDR_W  correct fetch address on mispredict.
REQ-019 o_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-020 Queue SHALL be an in-order circular buffer with head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus a count register.
REQ-021 o_push_ready SHALL equal (count < DEPTH) from registered count only; no same-cycle bypass from a resolve.
REQ-022 Push accepted when i_push_valid & o_push_ready & no flush event; entry {pc, target, prediction} written at tail, tail+1, count+1.
REQ-023 i_push_valid while not ready SHALL be dropped, state unchanged.
REQ-024 Resolve accepted when i_res_valid & count != 0 (registered); head entry read, head+1, count-1.
REQ-025 i_res_valid when count == 0 SHALL be ignored; an entry pushed in the same cycle SHALL NOT be resolvable until the next cycle.
REQ-026 Feedback SHALL be registered: one cycle after an accepted resolve, o_fb_valid=1 for exactly one cycle with o_fb_pc/o_fb_prediction of the head entry and o_fb_outcome = i_res_outcome.
REQ-027 Same cycle as o_fb_valid, o_mispredict = (outcome != prediction); o_recover_pc = target if outcome TAKEN, else pc + 8 (branch plus delay slot), ADDR_W-bit wrap-around.
REQ-028 o_recover_pc SHALL be 0 when o_mispredict is 0.
REQ-029 Mispredicting resolve SHALL discard all younger entries: at that edge head=tail, count=0; any push in that cycle dropped (wrong path).
REQ-030 i_flush SHALL clear head, tail, count at the edge; highest priority; concurrent push dropped, concurrent resolve ignored (no feedback produced).
REQ-031 Push and correct resolve in the same cycle with 0<count<DEPTH SHALL both take effect, count unchanged.
REQ-032 Push when full with concurrent resolve: resolve taken, push dropped, count = DEPTH-1.
REQ-033 Sustained one push + one resolve per cycle SHALL be supported without bubbles.

Reset
REQ-034 While rst_n=0 at posedge: head=tail=0, count=0, o_fb_valid=0, o_mispredict=0, o_fb_pc=0, o_recover_pc=0, o_fb_prediction=o_fb_outcome=NOT_TAKEN, o_push_ready=1 the cycle after.
REQ-035 Reset mid-operation SHALL discard all entries and suppress any pending feedback pulse; entry storage contents need not be cleared.

Verification
REQ-036 Push pc=0x100,tgt=0x200,pred=TAKEN; next cycle resolve TAKEN -> one cycle later o_fb_valid=1, o_fb_pc=0x100, o_mispredict=0, o_count=0.
REQ-037 Push pc=0x40,tgt=0x80,pred=TAKEN; resolve NOT_TAKEN -> o_mispredict=1, o_recover_pc=0x48; pc=0x40,pred=NOT_TAKEN, resolve TAKEN -> o_recover_pc=0x80.
REQ-038 Fill DEPTH=4 -> o_push_ready=0, 5th push dropped; push+resolve same cycle -> count=3, then 4 correct resolves return PCs in push order across pointer wrap.
REQ-039 Three entries queued, oldest mispredicts with concurrent push -> o_count=0 next cycle, only one o_fb_valid pulse, later resolves ignored.
REQ-040 i_flush with concurrent push and resolve at count=2 -> count=0, no o_fb_valid; rst_n=0 mid-stream -> REQ-034 values, no stale feedback.

Source files
------------

// File: rtl/branch_feedback_queue.sv
// In-order queue of predicted branches awaiting resolution; emits registered
// predictor feedback and a recovery PC when the oldest branch mispredicts.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

module branch_feedback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = `ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push_valid,
    input  logic [ADDR_W-1:0]           i_push_pc,
    input  logic [ADDR_W-1:0]           i_push_target,
    input  mips_core_pkg::BranchOutcome i_push_prediction,
    output logic                        o_push_ready,
    input  logic                        i_res_valid,
    input  mips_core_pkg::BranchOutcome i_res_outcome,
    input  logic                        i_flush,
    output logic                        o_fb_valid,
    output logic [ADDR_W-1:0]           o_fb_pc,
    output mips_core_pkg::BranchOutcome o_fb_prediction,
    output mips_core_pkg::BranchOutcome o_fb_outcome,
    output logic                        o_mispredict,
    output logic [ADDR_W-1:0]           o_recover_pc,
    output logic [$clog2(DEPTH):0]      o_count
);
    import mips_core_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] tgt_mem_q  [DEPTH];
    BranchOutcome      pred_mem_q [DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fb_valid_q, fb_valid_d;
    logic [ADDR_W-1:0] fb_pc_q, fb_pc_d;
    BranchOutcome      fb_pred_q, fb_pred_d;
    BranchOutcome      fb_out_q, fb_out_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] recover_q, recover_d;

    logic              push_ready, res_ok, mis_now, push_ok;
    logic [ADDR_W-1:0] head_pc, head_tgt;
    BranchOutcome      head_pred;

    always_comb begin
        push_ready = (count_q < FULL_CNT);
        head_pc    = pc_mem_q[head_q];
        head_tgt   = tgt_mem_q[head_q];
        head_pred  = pred_mem_q[head_q];
        // Only registered occupancy counts, so a same-cycle push is never resolvable.
        res_ok     = i_res_valid && (count_q != '0) && !i_flush;
        mis_now    = res_ok && (i_res_outcome != head_pred);
        push_ok    = i_push_valid && push_ready && !i_flush && !mis_now;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (mis_now) begin
            // Everything younger than the mispredicted branch is wrong-path.
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + PW'(1);
            if (res_ok)  head_d = head_q + PW'(1);
            case ({push_ok, res_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        fb_valid_d = res_ok;
        fb_pc_d    = fb_pc_q;
        fb_pred_d  = fb_pred_q;
        fb_out_d   = fb_out_q;
        if (res_ok) begin
            fb_pc_d   = head_pc;
            fb_pred_d = head_pred;
            fb_out_d  = i_res_outcome;
        end
        mis_d     = mis_now;
        recover_d = '0;
        if (mis_now) begin
            recover_d = (i_res_outcome == TAKEN) ? head_tgt : head_pc + ADDR_W'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fb_valid_q <= 1'b0;
            fb_pc_q    <= '0;
            fb_pred_q  <= NOT_TAKEN;
            fb_out_q   <= NOT_TAKEN;
            mis_q      <= 1'b0;
            recover_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fb_valid_q <= fb_valid_d;
            fb_pc_q    <= fb_pc_d;
            fb_pred_q  <= fb_pred_d;
            fb_out_q   <= fb_out_d;
            mis_q      <= mis_d;
            recover_q  <= recover_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            pc_mem_q[tail_q]   <= i_push_pc;
            tgt_mem_q[tail_q]  <= i_push_target;
            pred_mem_q[tail_q] <= i_push_prediction;
        end
    end

    assign o_push_ready    = push_ready;
    assign o_fb_valid      = fb_valid_q;
    assign o_fb_pc         = fb_pc_q;
    assign o_fb_prediction = fb_pred_q;
    assign o_fb_outcome    = fb_out_q;
    assign o_mispredict    = mis_q;
    assign o_recover_pc    = recover_q;
    assign o_count         = count_q;

endmodule
